instr_fetch_unit: RTL and testbench

- Upstream stage of instr_memory_block: owns the program counter, drives read_adress and consumes the returned instruction word.
- Presents a valid/stall handshake to decode, with a one-entry hold buffer so a decode stall never loses a word already read.
- Accepts branch and jump redirects from downstream and flushes the in-flight fetch.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 111 +++++++++++
 tb/tb_instr_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus: memory address/data plus the decode handshake and redirect inputs.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] read_adress;
    logic [DATA_W-1:0] instruction;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_pc;
    logic [15:0]       branch_offset;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;

    modport master (
        output read_adress, if_instr, if_pc, if_valid,
        input  instruction, stall, jump_en, jump_target, branch_en, branch_pc, branch_offset
    );

    modport slave (
        input  read_adress, if_instr, if_pc, if_valid,
        output instruction, stall, jump_en, jump_target, branch_en, branch_pc, branch_offset
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one-cycle memory read, one-entry hold buffer for decode stalls, redirects.
// Optional perf counters (fetches, bubbles) enabled with `define FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 14,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst_n,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);
    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc;
    logic              resp_valid;
    logic              hold_valid;
    logic [DATA_W-1:0] hold_instr;
    logic [ADDR_W-1:0] hold_pc;
    logic              redirect;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] redirect_pc;

    // Size cast of the signed offset sign-extends or truncates to ADDR_W, giving modulo arithmetic.
    assign br_target   = bus.branch_pc + ADDR_W'(1) + ADDR_W'($signed(bus.branch_offset));
    assign redirect    = bus.jump_en | bus.branch_en;
    assign redirect_pc = bus.jump_en ? bus.jump_target : br_target;
    assign bus.read_adress = pc_q;

    always_comb begin
        if (hold_valid) begin
            bus.if_instr = hold_instr;
            bus.if_pc    = hold_pc;
            bus.if_valid = 1'b1;
        end else begin
            // Memory data is masked while nothing valid is on the bus so reset shows zeros.
            bus.if_instr = resp_valid ? bus.instruction : '0;
            bus.if_pc    = resp_pc;
            bus.if_valid = resp_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            resp_pc    <= '0;
            resp_valid <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            resp_pc    <= pc_q;
            resp_valid <= !redirect;
            if (redirect) begin
                pc_q       <= redirect_pc;
                hold_valid <= 1'b0;
                state      <= FLUSH;
            end else begin
                case (state)
                    // The word at pc_q is being read now, so advance even though nothing is valid.
                    BOOT, FLUSH: begin
                        pc_q  <= pc_q + ADDR_W'(1);
                        state <= RUN;
                    end
                    RUN: begin
                        if (bus.stall) begin
                            hold_valid <= 1'b1;
                            hold_instr <= bus.if_instr;
                            hold_pc    <= bus.if_pc;
                            state      <= STALL;
                        end else begin
                            pc_q <= pc_q + ADDR_W'(1);
                        end
                    end
                    STALL: begin
                        if (!bus.stall) begin
                            hold_valid <= 1'b0;
                            pc_q       <= pc_q + ADDR_W'(1);
                            state      <= RUN;
                        end
                    end
                    default: state <= BOOT;
                endcase
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic accept;
    assign accept = bus.if_valid && !bus.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (accept && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (!bus.if_valid && state != BOOT && perf_bubble_cnt != '1)
                perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed plan scenarios plus a randomized
// run checked against a handshake-level model of the fetch stream.
module tb_instr_fetch_unit;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NW = 16384;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [DW-1:0] mem [0:NW-1];

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus_w ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt, w_fetch_cnt, w_bubble_cnt;
`endif

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(14'd0)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(14'd16382)) dut_w (
        .clk(clk), .rst_n(rst_n), .bus(bus_w)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(w_fetch_cnt), .perf_bubble_cnt(w_bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // One-cycle registered instruction memory shared by both instances.
    always @(posedge clk) begin
        bus.instruction   <= mem[bus.read_adress];
        bus_w.instruction <= mem[bus_w.read_adress];
    end

    task automatic clear_inputs();
        bus.stall = 0; bus.jump_en = 0; bus.jump_target = '0;
        bus.branch_en = 0; bus.branch_pc = '0; bus.branch_offset = '0;
    endtask

    task automatic test_reset_and_run();
        rst_n = 1'b0;
        @(negedge clk);
        checks += 5;
        if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", bus.if_valid); end
        if (bus.if_instr !== '0) begin failures++; $display("FAIL reset_instr got=%0h exp=0", bus.if_instr); end
        if (bus.if_pc !== '0) begin failures++; $display("FAIL reset_pc got=%0d exp=0", bus.if_pc); end
        if (bus.read_adress !== 14'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.read_adress); end
        if (bus_w.read_adress !== 14'd16382) begin failures++; $display("FAIL reset_addr_wrap got=%0d exp=16382", bus_w.read_adress); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 0 || perf_bubble_cnt !== 0) begin
            failures++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_bubble_cnt);
        end
`endif
        rst_n = 1'b1;
        #1;
        checks += 2;
        if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL boot_valid got=%0d exp=0", bus.if_valid); end
        if (bus.read_adress !== 14'd0) begin failures++; $display("FAIL boot_addr got=%0d exp=0", bus.read_adress); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks += 4;
            if (bus.if_valid !== 1'b1) begin failures++; $display("FAIL run_valid[%0d] got=%0d exp=1", k, bus.if_valid); end
            if (bus.if_pc !== AW'(k)) begin failures++; $display("FAIL run_pc[%0d] got=%0d exp=%0d", k, bus.if_pc, k); end
            if (bus.if_instr !== mem[k]) begin failures++; $display("FAIL run_instr[%0d] got=%0h exp=%0h", k, bus.if_instr, mem[k]); end
            if (bus.read_adress !== AW'(k + 1)) begin failures++; $display("FAIL run_addr[%0d] got=%0d exp=%0d", k, bus.read_adress, k + 1); end
            if (k < 4) begin
                checks += 2;
                if (bus_w.if_pc !== AW'((16382 + k) % NW) || bus_w.if_valid !== 1'b1) begin
                    failures++; $display("FAIL wrap_pc[%0d] got=%0d exp=%0d", k, bus_w.if_pc, (16382 + k) % NW);
                end
                if (bus_w.if_instr !== mem[(16382 + k) % NW]) begin
                    failures++; $display("FAIL wrap_instr[%0d] got=%0h exp=%0h", k, bus_w.if_instr, mem[(16382 + k) % NW]);
                end
            end
        end
    endtask

    // Entered with if_pc=5 on the bus.
    task automatic test_stall();
        bus.stall = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks += 3;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 14'd5) begin failures++; $display("FAIL stall_pc[%0d] got=%0d exp=5", i, bus.if_pc); end
            if (bus.if_instr !== mem[5]) begin failures++; $display("FAIL stall_instr[%0d] got=%0h exp=%0h", i, bus.if_instr, mem[5]); end
            if (bus.read_adress !== 14'd6) begin failures++; $display("FAIL stall_addr[%0d] got=%0d exp=6", i, bus.read_adress); end
        end
        bus.stall = 1'b0;
        for (int p = 6; p <= 7; p++) begin
            @(negedge clk);
            checks += 2;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(p)) begin failures++; $display("FAIL unstall_pc got=%0d exp=%0d", bus.if_pc, p); end
            if (bus.if_instr !== mem[p]) begin failures++; $display("FAIL unstall_instr got=%0h exp=%0h", bus.if_instr, mem[p]); end
        end
    endtask

    task automatic test_jump();
        int tgt[2] = '{3, 100};
        for (int j = 0; j < 2; j++) begin
            bus.jump_en = 1'b1; bus.jump_target = AW'(tgt[j]);
            @(negedge clk);
            bus.jump_en = 1'b0;
            checks += 2;
            if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL jump_bubble got=%0d exp=0", bus.if_valid); end
            if (bus.read_adress !== AW'(tgt[j])) begin failures++; $display("FAIL jump_addr got=%0d exp=%0d", bus.read_adress, tgt[j]); end
            @(negedge clk);
            checks += 2;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(tgt[j])) begin failures++; $display("FAIL jump_pc got=%0d exp=%0d", bus.if_pc, tgt[j]); end
            if (bus.if_instr !== mem[tgt[j]]) begin failures++; $display("FAIL jump_instr got=%0h exp=%0h", bus.if_instr, mem[tgt[j]]); end
        end
    endtask

    // Redirect while the hold buffer is full and stall stays high through the bubble.
    task automatic test_redirect_stall();
        bus.stall = 1'b1;
        @(negedge clk);
        bus.jump_en = 1'b1; bus.jump_target = 14'd50;
        @(negedge clk);
        bus.jump_en = 1'b0;
        checks += 2;
        if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL rs_bubble got=%0d exp=0", bus.if_valid); end
        if (bus.read_adress !== 14'd50) begin failures++; $display("FAIL rs_addr got=%0d exp=50", bus.read_adress); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 14'd50 || bus.if_instr !== mem[50]) begin
                failures++; $display("FAIL rs_pc[%0d] got=%0d exp=50", i, bus.if_pc);
            end
        end
        bus.stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.if_pc !== 14'd51) begin failures++; $display("FAIL rs_next got=%0d exp=51", bus.if_pc); end
    endtask

    task automatic test_branch();
        logic        je[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        int          jt[4]  = '{0, 9, 0, 0};
        int          bpc[4] = '{10, 10, 16383, 2};
        logic [15:0] off[4] = '{16'hFFFC, 16'hFFFC, 16'd5, 16'h8000};
        int          exp[4] = '{7, 9, 5, 3};
        for (int t = 0; t < 4; t++) begin
            bus.branch_en = 1'b1; bus.branch_pc = AW'(bpc[t]); bus.branch_offset = off[t];
            bus.jump_en = je[t]; bus.jump_target = AW'(jt[t]);
            @(negedge clk);
            clear_inputs();
            checks += 2;
            if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL br_bubble[%0d] got=%0d exp=0", t, bus.if_valid); end
            if (bus.read_adress !== AW'(exp[t])) begin failures++; $display("FAIL br_addr[%0d] got=%0d exp=%0d", t, bus.read_adress, exp[t]); end
            @(negedge clk);
            checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== AW'(exp[t]) || bus.if_instr !== mem[exp[t]]) begin
                failures++; $display("FAIL br_pc[%0d] got=%0d exp=%0d", t, bus.if_pc, exp[t]);
            end
        end
    endtask

    // Model: the stream is program-ordered words; a redirect or reset release costs one invalid cycle.
    task automatic test_random();
        int   exp_pc, n_fetch, n_bubble, tgt, r;
        bit   exp_valid, boot;
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_pc = 0; exp_valid = 0; boot = 1; n_fetch = 0; n_bubble = 0;
        for (int i = 0; i < 600; i++) begin
            checks++;
            if (bus.if_valid !== exp_valid) begin
                failures++; $display("FAIL rnd_valid[%0d] got=%0d exp=%0d", i, bus.if_valid, exp_valid);
            end else if (exp_valid) begin
                checks += 2;
                if (bus.if_pc !== AW'(exp_pc)) begin failures++; $display("FAIL rnd_pc[%0d] got=%0d exp=%0d", i, bus.if_pc, exp_pc); end
                if (bus.if_instr !== mem[exp_pc]) begin failures++; $display("FAIL rnd_instr[%0d] got=%0h exp=%0h", i, bus.if_instr, mem[exp_pc]); end
            end
            bus.stall = ($urandom_range(0, 99) < 30);
            r = $urandom_range(0, 99);
            bus.jump_en = (r < 5);
            bus.branch_en = (r >= 3 && r < 9);
            bus.jump_target = AW'($urandom_range(0, NW - 1));
            bus.branch_pc = AW'($urandom_range(0, NW - 1));
            bus.branch_offset = 16'($urandom);
            if (exp_valid && !bus.stall) n_fetch++;
            if (!exp_valid && !boot) n_bubble++;
            boot = 0;
            if (bus.jump_en || bus.branch_en) begin
                if (bus.jump_en) tgt = int'(bus.jump_target);
                else tgt = int'(bus.branch_pc) + 1 + int'($signed(bus.branch_offset));
                exp_pc = ((tgt % NW) + NW) % NW;
                exp_valid = 0;
            end else if (!exp_valid) begin
                exp_valid = 1;
            end else if (!bus.stall) begin
                exp_pc = (exp_pc + 1) % NW;
            end
            @(negedge clk);
        end
        clear_inputs();
`ifdef FETCH_PERF_CNT_EN
        checks += 2;
        if (perf_fetch_cnt !== 32'(n_fetch)) begin failures++; $display("FAIL perf_fetch got=%0d exp=%0d", perf_fetch_cnt, n_fetch); end
        if (perf_bubble_cnt !== 32'(n_bubble)) begin failures++; $display("FAIL perf_bubble got=%0d exp=%0d", perf_bubble_cnt, n_bubble); end
`else
        checks++;
        if (n_fetch == 0) begin failures++; $display("FAIL rnd_activity got=%0d exp=nonzero", n_fetch); end
`endif
    endtask

    task automatic test_reset_mid_stall();
        bus.jump_en = 1'b1; bus.jump_target = 14'd20;
        @(negedge clk);
        bus.jump_en = 1'b0;
        @(negedge clk);
        bus.stall = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 14'd20) begin failures++; $display("FAIL mid_pre got=%0d exp=20", bus.if_pc); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.if_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0d exp=0", bus.if_valid); end
        if (bus.read_adress !== 14'd0) begin failures++; $display("FAIL mid_addr got=%0d exp=0", bus.read_adress); end
        if (bus.if_pc !== '0) begin failures++; $display("FAIL mid_pc got=%0d exp=0", bus.if_pc); end
        if (bus.if_instr !== '0) begin failures++; $display("FAIL mid_instr got=%0h exp=0", bus.if_instr); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 0 || perf_bubble_cnt !== 0) begin
            failures++; $display("FAIL mid_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_bubble_cnt);
        end
`endif
        @(negedge clk);
        bus.stall = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 14'd0 || bus.if_instr !== mem[0]) begin
            failures++; $display("FAIL mid_restart got=%0d exp=0", bus.if_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = $urandom | 32'h1;
        clear_inputs();
        bus_w.stall = 0; bus_w.jump_en = 0; bus_w.jump_target = '0;
        bus_w.branch_en = 0; bus_w.branch_pc = '0; bus_w.branch_offset = '0;
        test_reset_and_run();
        test_stall();
        test_jump();
        test_redirect_stall();
        test_branch();
        test_random();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
